// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register: 2-entry skid buffer with valid/ready handshake,
// flush/stall control, bubble zeroing and saturating stall/flush counters.
module pipe_stage_buf #(
   parameter int unsigned W           = 32,
   parameter int unsigned BUBBLE_ZERO = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   input  logic             stall,
   input  logic             flush,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // State bits are {m_v, s_v}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [W-1:0]     m_d, m_d_nxt;
   logic [W-1:0]     s_d, s_d_nxt;
   logic [CNT_W-1:0] stall_cnt_nxt, flush_cnt_nxt;
   logic             m_v, s_v, rdy, acc, pop;

   assign m_v       = state[1];
   assign s_v       = state[0];
   assign out_valid = m_v;
   assign in_ready  = ~s_v;
   assign out_data  = m_d;

   assign rdy = out_ready & ~stall;
   assign acc = in_valid & in_ready;
   assign pop = m_v & rdy;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state     <= EMPTY;
         m_d       <= '0;
         s_d       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         m_d       <= m_d_nxt;
         s_d       <= s_d_nxt;
         stall_cnt <= stall_cnt_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      m_d_nxt   = m_d;
      s_d_nxt   = s_d;

      if (flush) begin
         // Flush beats any transfer; a same-cycle accepted beat is dropped.
         state_nxt = EMPTY;
         if (BUBBLE_ZERO != 0) m_d_nxt = '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  m_d_nxt   = in_data;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (pop && acc) begin
                  m_d_nxt = in_data;
               end else if (pop) begin
                  state_nxt = EMPTY;
                  if (BUBBLE_ZERO != 0) m_d_nxt = '0;
               end else if (acc) begin
                  s_d_nxt   = in_data;
                  state_nxt = FULL;
               end
            end
            FULL: begin
               if (pop) begin
                  m_d_nxt   = s_d;
                  state_nxt = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Saturating performance counters; clear wins over increment.
   always_comb begin
      stall_cnt_nxt = stall_cnt;
      flush_cnt_nxt = flush_cnt;
      if (clr_cnt) begin
         stall_cnt_nxt = '0;
         flush_cnt_nxt = '0;
      end else begin
         if (m_v && !rdy && stall_cnt != CNT_MAX)
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
         if (flush && (m_v || s_v) && flush_cnt != CNT_MAX)
            flush_cnt_nxt = flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_buf;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        stall;
   logic        flush;
   logic        clr_cnt;

   logic        in_ready,  in_ready_s;
   logic        out_valid, out_valid_s;
   logic [31:0] out_data,  out_data_s;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  stall_cnt_s, flush_cnt_s;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents plus counters for both counter widths.
   logic [31:0] mq[$];
   int m_sc, m_fc, m_sc2, m_fc2;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        st;
      logic        fl;
      logic        clr;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_od;
      int          e_sc;
      int          e_fc;
   } vec_t;

   vec_t tbl[21];

   pipe_stage_buf #(.W(32), .BUBBLE_ZERO(1), .CNT_W(16)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_buf #(.W(32), .BUBBLE_ZERO(1), .CNT_W(2)) dut_s (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
   endtask

   function automatic int sat_inc(input int v, input int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   task automatic model_step(input logic iv, input logic [31:0] d, input logic ordy,
                             input logic st, input logic fl, input logic clr);
      int  n;
      bit  rdy, acc, pop, s_inc, f_inc;
      n     = mq.size();
      rdy   = ordy && !st;
      acc   = iv && (n < 2);
      pop   = (n > 0) && rdy;
      s_inc = (n > 0) && !rdy;
      f_inc = fl && (n > 0);
      if (clr) begin
         m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
      end else begin
         if (s_inc) begin
            m_sc  = sat_inc(m_sc, 65535);
            m_sc2 = sat_inc(m_sc2, 3);
         end
         if (f_inc) begin
            m_fc  = sat_inc(m_fc, 65535);
            m_fc2 = sat_inc(m_fc2, 3);
         end
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
   endtask

   task automatic compare_model();
      logic        e_ov, e_ir;
      logic [31:0] e_od;
      e_ov = (mq.size() > 0);
      e_ir = (mq.size() < 2);
      e_od = (mq.size() > 0) ? mq[0] : 32'h0;
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("out_data", out_data, e_od);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
      chk("s_out_valid", 32'(out_valid_s), 32'(e_ov));
      chk("s_in_ready", 32'(in_ready_s), 32'(e_ir));
      chk("s_out_data", out_data_s, e_od);
      chk("s_stall_cnt", 32'(stall_cnt_s), 32'(m_sc2));
      chk("s_flush_cnt", 32'(flush_cnt_s), 32'(m_fc2));
   endtask

   task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic st, input logic fl, input logic clr);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      clr_cnt   = clr;
      @(posedge cpu_clk);
      model_step(iv, d, ordy, st, fl, clr);
      #1;
      compare_model();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_data"}, out_data, 32'h0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'h0);
      chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'h0);
      chk({tag, "_s_stall_cnt"}, 32'(stall_cnt_s), 32'h0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
      cpu_rst = 1'b1;
      #1;
      check_reset_outputs("rst");
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      // iv d ordy st fl clr | ov ir od sc fc
      tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 0, 0};
      tbl[1]  = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 0, 0};
      tbl[2]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h108, 0, 0};
      tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   0, 0};
      tbl[4]  = '{1'b1, 32'hA,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,   0, 0};
      tbl[5]  = '{1'b1, 32'hB,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,   1, 0};
      tbl[6]  = '{1'b1, 32'hC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,   2, 0};
      tbl[7]  = '{1'b1, 32'hC,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB,   2, 0};
      tbl[8]  = '{1'b1, 32'hC,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC,   2, 0};
      tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   2, 0};
      tbl[10] = '{1'b1, 32'h11,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,  2, 0};
      tbl[11] = '{1'b1, 32'h22,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11,  3, 0};
      tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4, 1};
      tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4, 1};
      tbl[14] = '{1'b1, 32'h33,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33,  4, 1};
      tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33,  5, 1};
      tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   6, 2};
      tbl[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   6, 2};
      tbl[18] = '{1'b1, 32'h44,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44,  6, 2};
      tbl[19] = '{1'b1, 32'h55,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   6, 3};
      tbl[20] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   0, 0};

      do_reset();

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl, tbl[i].clr);
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("tbl%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_sc));
         chk($sformatf("tbl%0d_flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].e_fc));
      end

      // Counter saturation on the 2-bit instance, then clear during a stall.
      do_reset();
      step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         int exp_small;
         exp_small = (i + 1 > 3) ? 3 : i + 1;
         step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk($sformatf("sat_small_%0d", i), 32'(stall_cnt_s), 32'(exp_small));
         chk($sformatf("sat_main_%0d", i), 32'(stall_cnt), 32'(i + 1));
      end
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr_small", 32'(stall_cnt_s), 32'h0);
      chk("clr_main", 32'(stall_cnt), 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("after_clr_small", 32'(stall_cnt_s), 32'h1);

      // Async reset between edges while FULL.
      do_reset();
      step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_async_in_ready", 32'(in_ready), 32'h0);
      #2;
      cpu_rst = 1'b1;
      #1;
      check_reset_outputs("async");
      chk("async_before_edge", 32'(cpu_clk), 32'h1);
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      model_reset();
      step(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_async_data", out_data, 32'hCC);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
